sync_rx_4phase: RTL and testbench
=================================

SYNC_RX_4PHASE -- requirements
Module: sync_rx_4phase

Interface
REQ-001 The block SHALL have parameter DATA_MSB, default 7, giving the MSB index of the data bus (width DATA_MSB+1).
REQ-002 The block SHALL have port clk_rx, input, 1, the receive-domain clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port req, input, 1: the 4-phase request from the transmit domain, asynchronous to clk_rx.
REQ-005 The block SHALL have port in_data, input, DATA_MSB+1: transmit data, held stable by the sender while req is high.
REQ-006 The block SHALL have port ack, output, 1: the 4-phase acknowledge returned to the transmit domain, registered.
REQ-007 The block SHALL have port out_data, output, DATA_MSB+1: the captured word, registered.
REQ-008 The block SHALL have port f, output, 1: full flag; out_data holds an unconsumed word.
REQ-009 The block SHALL have port rd, input, 1: consumer pop; it is ignored when f=0.
REQ-010 The block SHALL have port d, output, 1: a one-cycle done pulse marking completion of a full 4-phase cycle.
REQ-011 The block SHALL have port n_xfer, output, 8: the count of completed transfers, modulo 256.

Function
REQ-012 req SHALL pass through two flops (req_s1, req_s2) before any use; no other logic samples raw req.
REQ-013 The FSM SHALL have states IDLE (ack=0), ACK (ack=1) and REL (ack=0, one cycle).
REQ-014 In IDLE with req_s2=1 and (f=0 or rd=1), the block SHALL capture in_data into out_data, set f=1, and enter ACK with ack=1 at the same edge.
REQ-015 In IDLE with req_s2=1, f=1 and rd=0, the block SHALL remain in IDLE with ack=0 (back-pressure) and leave out_data unchanged.
REQ-016 In ACK, the block SHALL hold ack=1 until req_s2=0, then enter REL with ack=0.
REQ-017 Entering REL, the block SHALL pulse d=1 for exactly one cycle and increment n_xfer by 1; 255 SHALL wrap to 0.
REQ-018 REL SHALL always return to IDLE on the next edge; this guards against a stale req_s2 in the 4-phase return-to-zero.
REQ-019 rd with f=1 SHALL clear f on the next edge unless a capture occurs on the same edge, in which case f stays 1 and out_data takes the new word.
REQ-020 rd SHALL be accepted in any FSM state; out_data SHALL only change on a capture.
REQ-021 Latency: with req rising before edge E0, req_s2=1 after E1, and capture with ack=1 SHALL occur at E2 when the buffer is free (ack visible two edges after the first sampling edge).
REQ-022 Release latency: with req falling before edge E0, ack=0 and d=1 SHALL take effect at E2.
REQ-023 ack SHALL never rise while req_s2=0 and SHALL never fall while req_s2=1.

Reset
REQ-024 On reset=1 at an edge, the block SHALL set req_s1=0, req_s2=0, state=IDLE, ack=0, f=0, d=0, n_xfer=0 and out_data=0.
REQ-025 Reset SHALL override rd and req in the same cycle.
REQ-026 Reset mid-handshake (state ACK) SHALL drop ack; if req is still high after reset, the word SHALL be re-captured as a new transfer.

Verification
REQ-027 Basic transfer: reset, in_data=8'hA5, raise req -> ack=1 two edges after the first sampling edge, out_data=8'hA5, f=1; drop req -> ack=0 and d pulsed once two edges later, n_xfer=1.
REQ-028 Back-pressure: f=1 with out_data=8'h11, rd=0, second req with 8'h22 -> ack stays 0 and out_data=8'h11; pulse rd -> next edge captures 8'h22, ack=1, f stays 1.
REQ-029 Pop without refill: f=1, rd=1, req low -> f=0 next edge, out_data unchanged.
REQ-030 Counter wrap: 256 back-to-back transfers -> n_xfer returns to 0, exactly 256 d pulses, no ack glitch.
REQ-031 Reset in ACK with req held high: reset for 1 cycle -> ack=0, f=0, n_xfer=0; after reset, ack=1 re-rises and out_data=in_data.
REQ-032 Invariant check, all tests: ack changes only as per REQ-023, and d is never high for two consecutive cycles.

Source files
------------

// File: rtl/sync_rx_4phase.sv
// sync_rx_4phase: 4-phase req/ack receiver with a one-word output buffer.
// Latency: capture and ack two edges after req is first sampled; release and done pulse two edges after req falls.
// Backpressure: when the buffer is full and rd is low, ack is withheld, which stalls the sender's handshake.
//
// Ports:
//   clk_rx    receive-domain clock
//   reset     synchronous, active-high
//   req       4-phase request from the transmit domain (asynchronous)
//   in_data   transmit data, stable while req is high
//   ack       4-phase acknowledge back to the sender (registered)
//   out_data  captured word (registered)
//   f         full flag: out_data holds an unconsumed word
//   rd        consumer pop; ignored when f is low
//   d         one-cycle pulse when a full 4-phase cycle completes
//   n_xfer    completed transfer count, modulo 256
`timescale 1ns/1ps
module sync_rx_4phase #(
  parameter int DATA_MSB = 7
) (
  input  logic              clk_rx,
  input  logic              reset,
  input  logic              req,
  input  logic [DATA_MSB:0] in_data,
  output logic              ack,
  output logic [DATA_MSB:0] out_data,
  output logic              f,
  input  logic              rd,
  output logic              d,
  output logic [7:0]        n_xfer
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t            state_q;
  logic              req_s1_q;
  logic              req_s2_q;
  logic              ack_q;
  logic [DATA_MSB:0] out_data_q;
  logic              f_q;
  logic              d_q;
  logic [7:0]        n_xfer_q;

  // A capture needs a synchronised request and room in the buffer; a pop
  // on the same edge frees the slot, so the new word can replace the old.
  logic capture_d;
  assign capture_d = (state_q == IDLE) && req_s2_q && (!f_q || rd);

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      req_s1_q   <= 1'b0;
      req_s2_q   <= 1'b0;
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      out_data_q <= '0;
      f_q        <= 1'b0;
      d_q        <= 1'b0;
      n_xfer_q   <= 8'd0;
    end else begin
      // Two-flop synchroniser; nothing else looks at raw req.
      req_s1_q <= req;
      req_s2_q <= req_s1_q;
      d_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (capture_d) begin
            out_data_q <= in_data;
            ack_q      <= 1'b1;
            state_q    <= ACK;
          end
        end
        ACK: begin
          if (!req_s2_q) begin
            ack_q    <= 1'b0;
            d_q      <= 1'b1;
            n_xfer_q <= n_xfer_q + 8'd1;
            state_q  <= REL;
          end
        end
        REL: begin
          // One dead cycle so a stale synchroniser value cannot retrigger.
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase

      // Capture wins over pop: the slot is refilled on the same edge.
      if (capture_d) begin
        f_q <= 1'b1;
      end else if (rd && f_q) begin
        f_q <= 1'b0;
      end
    end
  end

  assign ack      = ack_q;
  assign out_data = out_data_q;
  assign f        = f_q;
  assign d        = d_q;
  assign n_xfer   = n_xfer_q;

endmodule

// File: tb/tb_sync_rx_4phase.sv
`timescale 1ns/1ps
module tb_sync_rx_4phase;

  logic       clk_rx = 1'b0;
  logic       reset;
  logic       req;
  logic [7:0] in_data;
  logic       ack;
  logic [7:0] out_data;
  logic       f;
  logic       rd;
  logic       d;
  logic [7:0] n_xfer;

  int tests = 0;
  int fails = 0;
  int d_count = 0;

  logic [7:0] exp_data_q[$];
  logic [7:0] exp_cnt_q[$];
  logic [7:0] exp_n;

  always #5 clk_rx = ~clk_rx;

  sync_rx_4phase #(.DATA_MSB(7)) dut (
    .clk_rx   (clk_rx),
    .reset    (reset),
    .req      (req),
    .in_data  (in_data),
    .ack      (ack),
    .out_data (out_data),
    .f        (f),
    .rd       (rd),
    .d        (d),
    .n_xfer   (n_xfer)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent model of the request synchroniser, used for the ack invariant.
  logic m_s1, m_s2, rst_seen;
  always @(posedge clk_rx) begin
    rst_seen <= reset;
    if (reset) begin
      m_s1 <= 1'b0;
      m_s2 <= 1'b0;
    end else begin
      m_s1 <= req;
      m_s2 <= m_s1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a capture or a done pulse.
  logic ack_prev = 1'b0, d_prev = 1'b0, s2_prev = 1'b0;
  always @(negedge clk_rx) begin
    logic [7:0] w;
    if (rst_seen !== 1'b1) begin
      if (ack === 1'b1 && ack_prev === 1'b0) begin
        check("ack_rise_with_req_s2", {31'd0, s2_prev}, 32'd1);
        if (exp_data_q.size() == 0) begin
          check("unexpected_capture", 32'd1, 32'd0);
        end else begin
          w = exp_data_q.pop_front();
          check("capture_data", {24'd0, out_data}, {24'd0, w});
          check("capture_full", {31'd0, f}, 32'd1);
        end
      end
      if (ack === 1'b0 && ack_prev === 1'b1) begin
        check("ack_fall_with_req_s2_low", {31'd0, s2_prev}, 32'd0);
      end
      if (d === 1'b1) begin
        d_count++;
        check("d_not_two_cycles", {31'd0, d_prev}, 32'd0);
        if (exp_cnt_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          w = exp_cnt_q.pop_front();
          check("done_count", {24'd0, n_xfer}, {24'd0, w});
        end
      end
    end
    ack_prev = ack;
    d_prev   = d;
    s2_prev  = m_s2;
  end

  task automatic wait_ack(input logic val, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!ok) begin
        @(negedge clk_rx);
        if (ack === val) ok = 1'b1;
      end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_xfer(input logic [7:0] data);
    in_data = data;
    exp_data_q.push_back(data);
    req = 1'b1;
    wait_ack(1'b1, "xfer_ack_rise");
    req = 1'b0;
    exp_n = exp_n + 8'd1;
    exp_cnt_q.push_back(exp_n);
    wait_ack(1'b0, "xfer_ack_fall");
    @(negedge clk_rx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1; req = 1'b0; rd = 1'b0; in_data = 8'h00; exp_n = 8'd0;
    repeat (3) @(negedge clk_rx);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_f", {31'd0, f}, 32'd0);
    check("rst_d", {31'd0, d}, 32'd0);
    check("rst_n_xfer", {24'd0, n_xfer}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk_rx);

    // Basic transfer with exact latency.
    in_data = 8'hA5;
    exp_data_q.push_back(8'hA5);
    req = 1'b1;
    @(negedge clk_rx); check("lat_ack_e0", {31'd0, ack}, 32'd0);
    @(negedge clk_rx); check("lat_ack_e1", {31'd0, ack}, 32'd0);
    @(negedge clk_rx); check("lat_ack_e2", {31'd0, ack}, 32'd1);
    check("basic_f", {31'd0, f}, 32'd1);
    req = 1'b0;
    exp_n = 8'd1;
    exp_cnt_q.push_back(exp_n);
    @(negedge clk_rx); check("rel_ack_e0", {31'd0, ack}, 32'd1);
    @(negedge clk_rx); check("rel_ack_e1", {31'd0, ack}, 32'd1);
    @(negedge clk_rx); check("rel_ack_e2", {31'd0, ack}, 32'd0);
    check("rel_d_e2", {31'd0, d}, 32'd1);
    check("basic_n_xfer", {24'd0, n_xfer}, 32'd1);
    @(negedge clk_rx); check("rel_d_one_cycle", {31'd0, d}, 32'd0);

    // Pop A5, then load 0x11 with the consumer idle.
    rd = 1'b1; @(negedge clk_rx); rd = 1'b0;
    check("pop_a5_f", {31'd0, f}, 32'd0);
    do_xfer(8'h11);
    check("bp_setup_f", {31'd0, f}, 32'd1);

    // Back-pressure: 0x22 offered while full.
    in_data = 8'h22;
    exp_data_q.push_back(8'h22);
    req = 1'b1;
    repeat (6) @(negedge clk_rx);
    check("bp_ack_held_low", {31'd0, ack}, 32'd0);
    check("bp_out_unchanged", {24'd0, out_data}, 32'h11);
    rd = 1'b1;
    @(negedge clk_rx);
    rd = 1'b0;
    check("bp_ack_after_rd", {31'd0, ack}, 32'd1);
    check("bp_f_stays", {31'd0, f}, 32'd1);
    req = 1'b0;
    exp_n = exp_n + 8'd1;
    exp_cnt_q.push_back(exp_n);
    wait_ack(1'b0, "bp_ack_fall");
    @(negedge clk_rx);

    // Pop without refill.
    rd = 1'b1;
    @(negedge clk_rx);
    rd = 1'b0;
    check("pop_f_clear", {31'd0, f}, 32'd0);
    check("pop_out_kept", {24'd0, out_data}, 32'h22);
    check("n_after_three", {24'd0, n_xfer}, 32'd3);

    // Reset while in ACK with req still high.
    in_data = 8'h5A;
    exp_data_q.push_back(8'h5A);
    req = 1'b1;
    wait_ack(1'b1, "rst_ack_first_rise");
    reset = 1'b1;
    exp_n = 8'd0;
    @(negedge clk_rx);
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    check("rst_mid_f", {31'd0, f}, 32'd0);
    check("rst_mid_n", {24'd0, n_xfer}, 32'd0);
    exp_data_q.push_back(8'h5A);
    reset = 1'b0;
    wait_ack(1'b1, "rst_recapture");
    req = 1'b0;
    exp_n = exp_n + 8'd1;
    exp_cnt_q.push_back(exp_n);
    wait_ack(1'b0, "rst_recap_fall");
    @(negedge clk_rx);
    check("rst_recap_n", {24'd0, n_xfer}, 32'd1);

    // Counter wrap: clean reset, then 256 transfers with the consumer always popping.
    reset = 1'b1;
    @(negedge clk_rx);
    reset = 1'b0;
    exp_n = 8'd0;
    rd = 1'b1;
    d0 = d_count;
    for (int i = 0; i < 256; i++) begin
      do_xfer(8'(i ^ 8'h3C));
    end
    rd = 1'b0;
    @(negedge clk_rx);
    check("wrap_n_xfer", {24'd0, n_xfer}, 32'd0);
    check("wrap_d_pulses", d_count - d0, 32'd256);
    check("scoreboard_data_empty", exp_data_q.size(), 32'd0);
    check("scoreboard_cnt_empty", exp_cnt_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
